// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES key-schedule generator.
// Loads PC-1(key) into the 28-bit C/D halves, then streams one PC-2 subkey
// per valid/ready handshake, in encrypt (K1..KR) or decrypt (KR..K1) order.
// Build option: define DES_KEY_PARITY_CHECK_EN to check every key byte for
// odd parity at load; without it key_parity_err is tied low.
module des_key_schedule #(
    parameter int unsigned ROUNDS     = 16,
    parameter logic [15:0] SHIFT_MASK = 16'h7EFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [0:63] key_in,
    output logic [0:47] subkey_out,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done,
    output logic        key_parity_err
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [4:0] ROUNDS_W = 5'(ROUNDS);

    // Tables hold DES bit numbers (1-based, bit 1 = MSB).
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state;
    state_t      state_next;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [27:0] c_rot;
    logic [27:0] d_rot;
    logic        decrypt_q;
    logic [4:0]  round_q;
    logic        rot_en;
    logic        rot_left;
    logic        rot_two;
    logic [3:0]  shift_idx;
    logic [3:0]  round_idx_next;
    logic [0:47] subkey_next;
    logic        accept_start;
    logic        issue;
    logic        last_accept;
    logic        parity_fail;

    // C/D are kept MSB-first: c[27] is the first bit of the C half.
    function automatic logic [55:0] pc1(input logic [0:63] k);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[6'(55 - i)] = k[6'(PC1_TAB[i] - 1)];
        end
        return cd;
    endfunction

    function automatic logic [0:47] pc2(input logic [55:0] cd);
        logic [0:47] k;
        k = '0;
        for (int i = 0; i < 48; i++) begin
            k[6'(i)] = cd[6'(56 - PC2_TAB[i])];
        end
        return k;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic en,
                                          input logic left, input logic two);
        logic [27:0] y;
        y = x;
        if (en) begin
            if (left) begin
                y = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
            end else begin
                y = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
            end
        end
        return y;
    endfunction

    assign accept_start = (state == IDLE) && start;
    assign issue        = (state == RUN) && (round_q <= ROUNDS_W) &&
                          (!subkey_valid || subkey_ready);
    assign last_accept  = (state == RUN) && subkey_valid && subkey_ready &&
                          (round_q > ROUNDS_W);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    // Rotation direction/amount and reported round number for the current round;
    // decrypt walks backwards and leaves the first (KR) subkey unrotated.
    always_comb begin
        rot_en         = 1'b1;
        rot_left       = 1'b1;
        shift_idx      = 4'(round_q - 5'd1);
        round_idx_next = 4'(round_q - 5'd1);
        if (decrypt_q) begin
            rot_left       = 1'b0;
            rot_en         = (round_q != 5'd1);
            shift_idx      = 4'(ROUNDS_W + 5'd1 - round_q);
            round_idx_next = 4'(ROUNDS_W - round_q);
        end
        rot_two = SHIFT_MASK[shift_idx];
    end

    assign c_rot       = rot28(c_q, rot_en, rot_left, rot_two);
    assign d_rot       = rot28(d_q, rot_en, rot_left, rot_two);
    assign subkey_next = pc2({c_rot, d_rot});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a key that fails the parity check skips straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = parity_fail ? DONE : LOAD;
            LOAD: state_next = RUN;
            RUN:  if (last_accept) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Key halves, round counter and the registered subkey/handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q          <= '0;
            d_q          <= '0;
            decrypt_q    <= 1'b0;
            round_q      <= '0;
            subkey_out   <= '0;
            subkey_valid <= 1'b0;
            round_idx    <= '0;
        end else begin
            if (accept_start) begin
                decrypt_q    <= decrypt;
                {c_q, d_q}   <= pc1(key_in);
                subkey_valid <= 1'b0;
            end
            if (state == LOAD) begin
                round_q <= 5'd1;
            end
            if (issue) begin
                c_q          <= c_rot;
                d_q          <= d_rot;
                subkey_out   <= subkey_next;
                round_idx    <= round_idx_next;
                subkey_valid <= 1'b1;
                round_q      <= round_q + 5'd1;
            end else if (last_accept) begin
                subkey_valid <= 1'b0;
            end
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    logic parity_err_q;

    // Every key byte must carry an odd number of ones.
    always_comb begin
        parity_fail = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (!(^key_in[6'(b * 8) +: 8])) parity_fail = 1'b1;
        end
    end

    // The parity verdict is refreshed on each accepted start and held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else if (accept_start) begin
            parity_err_q <= parity_fail;
        end
    end

    assign key_parity_err = parity_err_q;
`else
    logic unused_parity_bits;

    assign parity_fail        = 1'b0;
    assign key_parity_err     = 1'b0;
    assign unused_parity_bits = ^{key_in[7],  key_in[15], key_in[23], key_in[31],
                                  key_in[39], key_in[47], key_in[55], key_in[63]};
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: scoreboard bench for des_key_schedule.
// An independent bit-array model of the DES key schedule fills the expected
// queue when a key is started; a negedge monitor pops on every handshake.
module tb_des_key_schedule;

    localparam logic [63:0] KEY_STD = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY2    = 64'h0E329232EA6D0D73;
    localparam logic [63:0] KEY_BAD = 64'h123457799BBCDFF1;
    localparam logic [47:0] K1_STD  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_STD = 48'hCB3D8B0E17F5;

    typedef struct packed {
        logic [3:0]  idx;
        logic [47:0] k;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [0:63] key_in;
    logic [0:47] subkey_out;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;
    logic        key_parity_err;

    logic        start4;
    logic [0:63] key4;
    logic [0:47] subkey4;
    logic        valid4;
    logic [3:0]  idx4;
    logic        busy4;
    logic        done4;
    logic        par4;
    logic        ready4 = 1'b1;
    logic        decrypt4 = 1'b0;

    int          check_count = 0;
    int          err_count   = 0;
    int          done_count  = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [47:0] model_k [16];

    int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    des_key_schedule dut (
        .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_in(key_in),
        .subkey_out(subkey_out), .subkey_valid(subkey_valid),
        .subkey_ready(subkey_ready), .round_idx(round_idx), .busy(busy),
        .done(done), .key_parity_err(key_parity_err)
    );

    des_key_schedule #(.ROUNDS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .decrypt(decrypt4), .key_in(key4),
        .subkey_out(subkey4), .subkey_valid(valid4), .subkey_ready(ready4),
        .round_idx(idx4), .busy(busy4), .done(done4), .key_parity_err(par4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference schedule: cumulative left rotations on bit arrays, all 16 rounds.
    task automatic buildModel(input logic [63:0] key);
        bit          c [28];
        bit          d [28];
        bit          tc [28];
        bit          td [28];
        int          s;
        int          p;
        logic [47:0] k;
        for (int i = 0; i < 28; i++) begin
            c[i] = key[64 - PC1_T[i]];
            d[i] = key[64 - PC1_T[28 + i]];
        end
        for (int r = 0; r < 16; r++) begin
            s = (r == 0 || r == 1 || r == 8 || r == 15) ? 1 : 2;
            for (int i = 0; i < 28; i++) begin
                tc[i] = c[(i + s) % 28];
                td[i] = d[(i + s) % 28];
            end
            c = tc;
            d = td;
            k = '0;
            for (int j = 0; j < 48; j++) begin
                p = PC2_T[j];
                k = {k[46:0], (p <= 28) ? c[p - 1] : d[p - 29]};
            end
            model_k[r] = k;
        end
    endtask

    // Start a run on the main instance and queue the expected subkeys.
    task automatic applyStimulus(input logic [63:0] key, input logic dec);
        exp_t e;
        buildModel(key);
        for (int i = 0; i < 16; i++) begin
            e.idx = dec ? 4'(15 - i) : 4'(i);
            e.k   = model_k[e.idx];
            exp_q.push_back(e);
        end
        key_in  = key;
        decrypt = dec;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic waitValidIdx(input logic [3:0] idx, input int budget, input string tag);
        int n = 0;
        while (!(subkey_valid && round_idx == idx) && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, "_reached"}, 64'(subkey_valid && round_idx == idx), 64'd1);
    endtask

    task automatic runFixed(input logic dec, input string tag,
                            input logic [47:0] first_k, input logic [3:0] first_i,
                            input logic [47:0] last_k, input logic [3:0] last_i);
        int dc;
        dc = done_count;
        applyStimulus(KEY_STD, dec);
        checkOutput({tag, "_lat0_valid"}, 64'(subkey_valid), 64'd0);
        tick();
        checkOutput({tag, "_lat1_valid"}, 64'(subkey_valid), 64'd0);
        tick();
        checkOutput({tag, "_first_valid"}, 64'(subkey_valid), 64'd1);
        checkOutput({tag, "_first_key"}, 64'(subkey_out), 64'(first_k));
        checkOutput({tag, "_first_idx"}, 64'(round_idx), 64'(first_i));
        repeat (15) tick();
        checkOutput({tag, "_last_key"}, 64'(subkey_out), 64'(last_k));
        checkOutput({tag, "_last_idx"}, 64'(round_idx), 64'(last_i));
        tick();
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        checkOutput({tag, "_valid_low"}, 64'(subkey_valid), 64'd0);
        tick();
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
        checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done_count"}, 64'(done_count - dc), 64'd1);
        checkOutput({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: every handshake on the main instance consumes one entry.
    always @(negedge clk) begin
        if (!rst && done) done_count++;
        if (!rst && subkey_valid && subkey_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_subkey", 64'(subkey_out), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("sb_subkey", 64'(subkey_out), 64'(mon_e.k));
                checkOutput("sb_round_idx", 64'(round_idx), 64'(mon_e.idx));
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int dc;
        rst          = 1'b1;
        start        = 1'b0;
        decrypt      = 1'b0;
        key_in       = '0;
        subkey_ready = 1'b1;
        start4       = 1'b0;
        key4         = '0;
        repeat (3) tick();
        checkOutput("rst_subkey", 64'(subkey_out), 64'd0);
        checkOutput("rst_valid", 64'(subkey_valid), 64'd0);
        checkOutput("rst_idx", 64'(round_idx), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_parity", 64'(key_parity_err), 64'd0);
        rst = 1'b0;
        tick();

        $display("[TB] encrypt run");
        runFixed(1'b0, "enc", K1_STD, 4'd0, K16_STD, 4'd15);

        $display("[TB] decrypt run");
        runFixed(1'b1, "dec", K16_STD, 4'd15, K1_STD, 4'd0);

        $display("[TB] backpressure at round 3");
        applyStimulus(KEY_STD, 1'b0);
        waitValidIdx(4'd2, 20, "bp");
        subkey_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_hold_key", 64'(subkey_out), 64'(model_k[2]));
            checkOutput("bp_hold_idx", 64'(round_idx), 64'd2);
            checkOutput("bp_hold_valid", 64'(subkey_valid), 64'd1);
        end
        subkey_ready = 1'b1;
        waitDone(40, "bp");
        tick();
        checkOutput("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] ignored start and reset at round 8");
        applyStimulus(KEY_STD, 1'b0);
        repeat (3) tick();
        key_in  = KEY2;
        decrypt = 1'b1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        waitValidIdx(4'd7, 20, "rst_mid");
        dc  = done_count;
        rst = 1'b1;
        tick();
        checkOutput("rst_mid_subkey", 64'(subkey_out), 64'd0);
        checkOutput("rst_mid_valid", 64'(subkey_valid), 64'd0);
        checkOutput("rst_mid_idx", 64'(round_idx), 64'd0);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_done", 64'(done), 64'd0);
        exp_q.delete();
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("rst_mid_no_done", 64'(done_count - dc), 64'd0);
        applyStimulus(KEY2, 1'b0);
        waitDone(40, "rst_new");
        tick();
        checkOutput("rst_new_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef DES_KEY_PARITY_CHECK_EN
        $display("[TB] parity check");
        key_in  = KEY_BAD;
        decrypt = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        checkOutput("par_err_set", 64'(key_parity_err), 64'd1);
        checkOutput("par_done", 64'(done), 64'd1);
        checkOutput("par_busy", 64'(busy), 64'd1);
        checkOutput("par_no_valid", 64'(subkey_valid), 64'd0);
        tick();
        checkOutput("par_err_hold", 64'(key_parity_err), 64'd1);
        checkOutput("par_idle", 64'(busy), 64'd0);
        applyStimulus(KEY_STD, 1'b0);
        checkOutput("par_err_clear", 64'(key_parity_err), 64'd0);
        waitDone(40, "par_good");
        tick();
        checkOutput("par_queue_empty", 64'(exp_q.size()), 64'd0);
`else
        $display("[TB] parity check disabled, bad-parity key runs normally");
        applyStimulus(KEY_BAD, 1'b0);
        checkOutput("nopar_err_low", 64'(key_parity_err), 64'd0);
        waitDone(40, "nopar");
        checkOutput("nopar_err_still_low", 64'(key_parity_err), 64'd0);
        tick();
        checkOutput("nopar_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

        $display("[TB] ROUNDS=4 instance");
        buildModel(KEY_STD);
        key4   = KEY_STD;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int n = 0; n < 10 && !valid4; n++) tick();
        checkOutput("r4_first_valid", 64'(valid4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("r4_subkey", 64'(subkey4), 64'(model_k[i]));
            checkOutput("r4_idx", 64'(idx4), 64'(i));
            tick();
        end
        checkOutput("r4_valid_low", 64'(valid4), 64'd0);
        checkOutput("r4_done", 64'(done4), 64'd1);
        tick();
        checkOutput("r4_idle", 64'(busy4), 64'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, err_count);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES key-schedule generator. Takes a 64-bit key and streams the round subkeys K1..K16 (encrypt order) or K16..K1 (decrypt order), one per accepted handshake.
- Applies PC-1 once at load, then per round: rotates the 28-bit C/D halves, applies PC-2, registers the 48-bit subkey.
- Sits between the key register and the round datapath. Round count and shift schedule are parametrised.

Parameters:
ROUNDS, 16, number of subkeys generated per key (1..16)
SHIFT_MASK, 16'h7EFC, bit r-1 = 1 means round r rotates by 2, else by 1 (FIPS 46-3 default)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  load request; sampled only in IDLE
decrypt  input  1  mode, sampled with start; 1 = reverse subkey order
key_in  input  [0:63]  key, bit 0 = DES bit 1 (MSB), sampled with start
subkey_out  output  [0:47]  current subkey, PC-2 numbering, bit 0 = DES bit 1
subkey_valid  output  1  subkey_out holds an unconsumed subkey
subkey_ready  input  1  consumer accepts subkey when valid && ready
round_idx  output  4  DES round number of subkey_out (0 = round 1), reverse-counting in decrypt
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last subkey is accepted
key_parity_err  output  1  see Optional Feature

Behaviour:
- Reset: state IDLE. subkey_out=0, subkey_valid=0, round_idx=0, busy=0, done=0, key_parity_err=0. C/D registers = 0. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE: start=1 captures decrypt, latches PC-1(key_in) into C (28 bits) and D (28 bits), then moves to LOAD. PC-1 drops parity bits 7,15,...,63.
- LOAD: one cycle. The round counter r is set to 1.
- RUN: a new subkey is produced when subkey_valid=0 or (subkey_valid && subkey_ready).
  - Encrypt: C,D <= rotl(C,D, s(r)); subkey_out <= PC2(rotated C||D); round_idx <= r-1.
  - Decrypt, r=1: no rotation.
  - Decrypt, r>1: rotr by s(ROUNDS+2-r); round_idx <= ROUNDS-r.
  - s(r) = 2 if SHIFT_MASK[r-1] else 1.
  - subkey_valid <= 1; r <= r+1.
- Latency: first subkey_valid rises 2 cycles after the start edge. With ready held high, one subkey per cycle (ROUNDS consecutive cycles).
- Backpressure: while valid && !ready, subkey_out, round_idx and C/D hold stable.
- After the handshake of round ROUNDS: subkey_valid <= 0, go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy falls when back in IDLE.
- start while busy is ignored. Key and mode are not re-sampled.
- Decrypt correctness requires the total rotation over ROUNDS to be ≡ 0 mod 28 (true for the default). Other settings give the defined reverse walk from PC-1 state, with no further guarantee.
- Rotations wrap within each 28-bit half independently.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN.
- With the macro: in IDLE on start, each key byte is checked for odd parity.
  - Any even byte: key_parity_err <= 1, no subkeys are issued, state goes to DONE (done pulses), busy behaves normally.
  - key_parity_err holds until the next accepted start or reset.
- Without the macro: no check is made; key_parity_err is tied to 0.

Test Plan:
- Encrypt, key 0x133457799BBCDFF1, ready=1 -> PC-1 gives C=0xF0CCAAF, D=0x556678F. First subkey_out=0x1B02EFFC7072, round_idx=0, 2 cycles after start. 16th=0xCB3D8B0E17F5, round_idx=15. done 1 cycle after last.
- Decrypt, same key -> first subkey=0xCB3D8B0E17F5 (round_idx=15), last=0x1B02EFFC7072 (round_idx=0), 16 subkeys total.
- Backpressure: ready low for 5 cycles at round 3 -> subkey_out and round_idx stable. No subkey is skipped or duplicated; the full 16-subkey sequence matches the encrypt case.
- Reset asserted at round 8, then start with a new key -> outputs return to reset values the next cycle, no done pulse. The new run starts cleanly from round 0. A start pulse issued mid-run is ignored.
- DES_KEY_PARITY_CHECK_EN, key 0x123457799BBCDFF1 -> key_parity_err=1, no subkey_valid, done pulses. Key 0x133457799BBCDFF1 -> key_parity_err=0 and normal run.
- ROUNDS=4, SHIFT_MASK default, encrypt -> exactly 4 subkeys, equal to standard K1..K4, then done.
